// File: rtl/wb_result_stage_pkg.sv
// Shared writeback-stage types: result source encoding, load funct3 codes and the buffered entry layout.
package wb_pkg;

  typedef enum logic [2:0] {
    RES_ALU  = 3'd0,
    RES_LOAD = 3'd1,
    RES_PC4  = 3'd2,
    RES_IMM  = 3'd3,
    RES_CSR  = 3'd4
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam int WB_XLEN   = 32;
  localparam int WB_REG_AW = 5;

  // Entry layout for the default core configuration; the stage sizes its own copy from its parameters.
  typedef struct packed {
    logic                 reg_write;
    logic [WB_REG_AW-1:0] rd;
    logic [WB_XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_stage_load_extend.sv
// Load lane select and sign/zero extension of a raw aligned memory word.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);

  // On RV32 the word holds only four byte lanes, so address bit 2 is dropped.
  localparam logic [2:0] AMASK = (XLEN == 64) ? 3'b111 : 3'b011;

  logic [2:0]      lane_addr;
  logic [XLEN-1:0] sh;

  always_comb begin
    unique case (funct3)
      F3_LB, F3_LBU: lane_addr = addr & AMASK;
      F3_LH, F3_LHU: lane_addr = addr & AMASK & 3'b110;
      F3_LW, F3_LWU: lane_addr = addr & AMASK & 3'b100;
      default:       lane_addr = 3'b000;
    endcase
    sh = raw >> {lane_addr, 3'b000};
  end

  always_comb begin
    unique case (funct3)
      F3_LB:   data = XLEN'($signed(sh[7:0]));
      F3_LBU:  data = XLEN'(sh[7:0]);
      F3_LH:   data = XLEN'($signed(sh[15:0]));
      F3_LHU:  data = XLEN'(sh[15:0]);
      F3_LW:   data = XLEN'($signed(sh[31:0]));
      F3_LWU:  data = XLEN'(sh[31:0]);
      // LD, and the unused code, return the whole word; on RV32 that is exactly LW.
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/wb_result_stage.sv
// Writeback stage: result source mux, load extension and a 2-entry skid buffer feeding the
// register-file write port and the WB forwarding bus.
module wb_result_stage
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        result_src,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   read_data,
  input  logic [XLEN-1:0]   pc_plus_4,
  input  logic [XLEN-1:0]   imm_ext,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic [2:0]        load_funct3,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              fwd_valid
);

  typedef struct packed {
    logic              reg_write;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } entry_t;

  logic [XLEN-1:0] load_data;
  entry_t          in_entry;
  entry_t          head;
  entry_t          buf_q [2];
  logic            head_q;
  logic [1:0]      count_q;
  logic [1:0]      count_d;
  logic            tail;
  logic            push;
  logic            pop;
  logic            head_writes;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (load_funct3),
    .addr   (alu_result[2:0]),
    .raw    (read_data),
    .data   (load_data)
  );

  always_comb begin
    in_entry.reg_write = reg_write;
    in_entry.rd        = rd_addr;
    unique case (result_src_e'(result_src))
      RES_ALU:  in_entry.data = alu_result;
      RES_LOAD: in_entry.data = load_data;
      RES_PC4:  in_entry.data = pc_plus_4;
      RES_IMM:  in_entry.data = imm_ext;
      RES_CSR:  in_entry.data = csr_rdata;
      default: begin
        in_entry.data      = '0;
        in_entry.reg_write = 1'b0;
      end
    endcase
  end

  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop};
  // Single-register mode never advances the head, so slot 0 is the only slot used.
  assign tail      = (SKID_EN != 0) ? (head_q ^ count_q[0]) : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
      if (pop && (SKID_EN != 0)) head_q <= ~head_q;
      if (push) buf_q[tail] <= in_entry;
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      logic rdy_q;
      // Registered from the next count so a full buffer never accepts in the cycle it drains.
      always_ff @(posedge clk) begin
        if (reset || flush) rdy_q <= 1'b1;
        else                rdy_q <= (count_d != 2'd2);
      end
      assign in_ready = rdy_q;
    end else begin : g_single
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  assign head        = buf_q[head_q];
  assign head_writes = out_valid & head.reg_write & (head.rd != '0);
  assign rf_waddr    = head.rd;
  assign rf_wdata    = head.data;
  assign rf_we       = head_writes & out_ready;
  assign fwd_valid   = head_writes;

endmodule
